// File: rtl/ps2_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_mmio_pkg
// Purpose : Register map, STATUS bit positions and rx FSM states for the
//           memory-mapped PS/2 keyboard receiver.
// Rev     : 1.0
// ============================================================================
package ps2_mmio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_PERR      = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                    input logic stop);
    return stop & (^{data, par});
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ps2_sync_fifo
// Purpose : Single-clock FIFO; a pop frees a slot for a same-cycle push.
// Rev     : 1.0
// ============================================================================
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_mmio.sv
`default_nettype none
// ============================================================================
// Module  : ps2_keyboard_mmio
// Purpose : PS/2 keyboard receiver with scan-code FIFO and DATA/STATUS/CTRL
//           bus registers plus a level interrupt.
// Rev     : 1.0
// ============================================================================
module ps2_keyboard_mmio
  import ps2_mmio_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              enable,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ReadData,
  output logic              irq,
  output logic [7:0]        code
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  rx_state_e              state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q, code_q;
  logic                   parity_q, ovf_q, ovf_d, perr_q, perr_d, irq_q;
  logic [TW-1:0]          tmo_q;
  logic [1:0]             ctrl_q;

  logic          w_fall, w_data, w_tmo_hit, w_push, w_perr_set, w_ovf_set;
  logic          w_rd, w_wr, w_pop, w_full, w_empty;
  logic [1:0]    w_off;
  logic [7:0]    w_dout;
  logic [CW-1:0] w_count;
  logic [15:0]   w_status;
  logic          w_unused_bits;

  assign w_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign w_data = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  // Timeout counts idle clk cycles between falling edges of a partial frame.
  assign w_tmo_hit  = (state_q != RX_IDLE) && !w_fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign w_push     = w_fall && (state_q == RX_STOP) && frame_ok(shift_q, parity_q, w_data);
  assign w_perr_set = w_tmo_hit ||
                      (w_fall && (state_q == RX_STOP) && !frame_ok(shift_q, parity_q, w_data));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      code_q    <= '0;
    end else begin
      if (w_push) code_q <= shift_q;
      if (state_q == RX_IDLE || w_fall) tmo_q <= '0;
      else                              tmo_q <= tmo_q + 1'b1;
      if (w_tmo_hit) begin
        state_q <= RX_IDLE;
      end else if (w_fall) begin
        case (state_q)
          RX_IDLE: begin
            if (!w_data && ctrl_q[CTRL_RX_EN]) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q   <= {w_data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_q <= w_data;
            state_q  <= RX_STOP;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign w_off = DataAdr[3:2];
  assign w_rd  = enable & ~MemWrite;
  assign w_wr  = enable & MemWrite;
  assign w_pop = w_rd && (w_off == REG_DATA);

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .din_i   (shift_q),
    .pop_i   (w_pop),
    .dout_o  (w_dout),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // A push into a full FIFO is only lost when no pop frees a slot that cycle.
  assign w_ovf_set = w_push && w_full && !(w_pop && !w_empty);

  always_comb begin
    ovf_d  = w_ovf_set  | (ovf_q  & ~(w_wr && (w_off == REG_STATUS) && WriteData[ST_OVF]));
    perr_d = w_perr_set | (perr_q & ~(w_wr && (w_off == REG_STATUS) && WriteData[ST_PERR]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ctrl_q <= 2'b01;
      irq_q  <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
      if (w_wr && (w_off == REG_CTRL)) ctrl_q <= WriteData[1:0];
      irq_q  <= ctrl_q[CTRL_IRQ_EN] & (~w_empty | ovf_q | perr_q);
    end
  end

  always_comb begin
    w_status                             = '0;
    w_status[ST_NOT_EMPTY]               = ~w_empty;
    w_status[ST_FULL]                    = w_full;
    w_status[ST_OVF]                     = ovf_q;
    w_status[ST_PERR]                    = perr_q;
    w_status[ST_COUNT_LSB +: 8]          = 8'(w_count);
    ReadData = '0;
    if (w_rd) begin
      case (w_off)
        REG_DATA:   ReadData = w_empty ? '0 : DATA_W'(w_dout);
        REG_STATUS: ReadData = DATA_W'(w_status);
        REG_CTRL:   ReadData = DATA_W'(ctrl_q);
        default:    ReadData = '0;
      endcase
    end
  end

  assign w_unused_bits = ^{DataAdr[ADDR_W-1:4], DataAdr[1:0], WriteData[DATA_W-1:4]};

  assign irq  = irq_q;
  assign code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_mmio.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_keyboard_mmio
// Purpose : Self-checking bench for ps2_keyboard_mmio against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_ps2_keyboard_mmio;

  localparam int TMO   = 200;
  localparam int HALF  = 10;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        enable = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        irq;
  logic [7:0]  code;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_perr = 1'b0;
  logic [7:0] m_code = '0;

  always #5 clk = ~clk;

  ps2_keyboard_mmio #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .enable    (enable),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .irq       (irq),
    .code      (code)
  );

  // ---------------- reference model ----------------
  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic good);
    if (good) begin
      m_code = b;
      if (mq.size() < DEPTH) mq.push_back(b);
      else                   m_ovf = 1'b1;
    end else begin
      m_perr = 1'b1;
    end
  endfunction

  function automatic logic [7:0] model_pop();
    if (mq.size() == 0) return 8'h00;
    return mq.pop_front();
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (mq.size() != 0);
    s[1]     = (mq.size() == DEPTH);
    s[2]     = m_ovf;
    s[3]     = m_perr;
    s[15:8]  = 8'(mq.size());
    return s;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    m_code = '0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic ps2_bit(input logic b);
    repeat (HALF) @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] off, output logic [31:0] val);
    @(negedge clk);
    enable = 1'b1; MemWrite = 1'b0; DataAdr = {28'h0, off, 2'b00};
    #1 val = ReadData;
    @(negedge clk);
    enable = 1'b0; DataAdr = '0;
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [31:0] val);
    @(negedge clk);
    enable = 1'b1; MemWrite = 1'b1; DataAdr = {28'h0, off, 2'b00}; WriteData = val;
    @(negedge clk);
    enable = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_cmp++; if (code !== 8'h00) begin n_err++; $display("FAIL reset_code: got %h expected 00", code); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL reset_status: got %h expected %h", rd, model_status()); end
    bus_rd(2'd2, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00000001", rd); end
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd(2'd3, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reg3_read: got %h expected 0", rd); end
    bus_rd(2'd2, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL reg3_write_ignored: got %h expected 00000001", rd); end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd, exp;
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    model_frame(8'h1C, 1'b1);
    n_cmp++; if (code !== m_code) begin n_err++; $display("FAIL frame_code: got %h expected %h", code, m_code); end
    n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL unselected_readdata: got %h expected 0", ReadData); end
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL frame_status: got %h expected %h", rd, model_status()); end
    bus_rd(2'd0, rd);
    exp = {24'h0, model_pop()};
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL frame_data: got %h expected %h", rd, exp); end
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL frame_status_after_pop: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_parity_err();
    logic [31:0] rd;
    send_frame(8'h1C, ~odd_par(8'h1C), 1'b1);
    model_frame(8'h1C, 1'b0);
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL perr_status: got %h expected %h", rd, model_status()); end
    bus_wr(2'd1, 32'h8);
    m_perr = 1'b0;
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL perr_clear: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, exp;
    logic [7:0]  b;
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b, odd_par(b), 1'b1);
      model_frame(b, 1'b1);
    end
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL ovf_status: got %h expected %h", rd, model_status()); end
    for (int i = 0; i < 9; i++) begin
      bus_rd(2'd0, rd);
      exp = {24'h0, model_pop()};
      n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, rd, exp); end
    end
    bus_wr(2'd1, 32'h4);
    m_ovf = 1'b0;
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL ovf_clear: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd, exp;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    m_perr = 1'b1;
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL timeout_status: got %h expected %h", rd, model_status()); end
    send_frame(8'h2A, odd_par(8'h2A), 1'b1);
    model_frame(8'h2A, 1'b1);
    n_cmp++; if (code !== m_code) begin n_err++; $display("FAIL timeout_next_code: got %h expected %h", code, m_code); end
    bus_rd(2'd0, rd);
    exp = {24'h0, model_pop()};
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL timeout_next_data: got %h expected %h", rd, exp); end
    bus_wr(2'd1, 32'hC);
    m_perr = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [31:0] rd, exp;
    logic [7:0]  b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, odd_par(b), 1'b1);
      model_frame(b, 1'b1);
    end
    b = 8'($urandom);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(odd_par(b));
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    // Two sync stages: the push lands on the third rising edge.
    @(posedge clk); @(posedge clk);
    #1 enable = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0;
    #1 rd = ReadData;
    @(posedge clk);
    #1 enable = 1'b0;
    exp = {24'h0, model_pop()};
    model_frame(b, 1'b1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL pushpop_data: got %h expected %h", rd, exp); end
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL pushpop_status: got %h expected %h", rd, model_status()); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(2'd0, rd);
      exp = {24'h0, model_pop()};
      n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL pushpop_drain[%0d]: got %h expected %h", i, rd, exp); end
    end
  endtask

  task automatic test_rx_disable();
    logic [31:0] rd;
    logic [7:0]  b;
    bus_wr(2'd2, 32'h0);
    send_frame(8'h33, odd_par(8'h33), 1'b1);
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL rxdis_ignored: got %h expected %h", rd, model_status()); end
    bus_wr(2'd2, 32'h1);
    b = 8'h6E;
    ps2_bit(1'b0);
    ps2_bit(b[0]); ps2_bit(b[1]);
    bus_wr(2'd2, 32'h0);
    for (int i = 2; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(odd_par(b));
    ps2_bit(1'b1);
    repeat (4) @(negedge clk);
    model_frame(b, 1'b1);
    bus_rd(2'd1, rd);
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL rxdis_midframe: got %h expected %h", rd, model_status()); end
    bus_rd(2'd0, rd);
    n_cmp++; if (rd !== {24'h0, model_pop()}) begin n_err++; $display("FAIL rxdis_data: got %h expected %h", rd, b); end
    bus_wr(2'd2, 32'h1);
  endtask

  task automatic test_irq_reset();
    logic [31:0] rd, exp;
    send_frame(8'h4B, odd_par(8'h4B), 1'b1);
    model_frame(8'h4B, 1'b1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b expected 0", irq); end
    bus_wr(2'd2, 32'h3);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b expected 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_raise: got %b expected 1", irq); end
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_premid: got %b expected 1", irq); end
    #3 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b expected 0", irq); end
    enable = 1'b1; MemWrite = 1'b0; DataAdr = 32'h4;
    #1 rd = ReadData;
    n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL rst_status: got %h expected %h", rd, model_status()); end
    DataAdr = 32'h8;
    #1 rd = ReadData;
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL rst_ctrl: got %h expected 00000001", rd); end
    enable = 1'b0; DataAdr = '0;
    ps2_data = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    model_frame(8'h5A, 1'b1);
    n_cmp++; if (code !== m_code) begin n_err++; $display("FAIL rst_after_code: got %h expected %h", code, m_code); end
    bus_rd(2'd0, rd);
    exp = {24'h0, model_pop()};
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rst_after_data: got %h expected %h", rd, exp); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp;
    logic [7:0]  b;
    logic        par, stop;
    int          r, e;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        b    = 8'($urandom);
        e    = $urandom_range(0, 7);
        par  = (e == 0) ? ~odd_par(b) : odd_par(b);
        stop = (e == 1) ? 1'b0 : 1'b1;
        send_frame(b, par, stop);
        model_frame(b, (e > 1));
        n_cmp++; if (code !== m_code) begin n_err++; $display("FAIL rnd_code[%0d]: got %h expected %h", it, code, m_code); end
      end else if (r <= 7) begin
        bus_rd(2'd0, rd);
        exp = {24'h0, model_pop()};
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", it, rd, exp); end
      end else if (r == 8) begin
        bus_rd(2'd1, rd);
        n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL rnd_status[%0d]: got %h expected %h", it, rd, model_status()); end
      end else begin
        exp = {28'h0, 2'($urandom), 2'b00};
        bus_wr(2'd1, exp);
        if (exp[2]) m_ovf  = 1'b0;
        if (exp[3]) m_perr = 1'b0;
        bus_rd(2'd1, rd);
        n_cmp++; if (rd !== model_status()) begin n_err++; $display("FAIL rnd_w1c[%0d]: got %h expected %h", it, rd, model_status()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_push_pop();
    test_rx_disable();
    test_irq_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_mmio.md
Name: ps2_keyboard_mmio

Overview:
Memory-mapped PS/2 keyboard receiver for the ARM single-cycle SoC. It replaces the separate keyboard driver and keyboard register pair with one block.
- Deserialises PS/2 frames and checks odd parity and the stop bit.
- Buffers scan codes in a parametrised FIFO.
- Exposes DATA/STATUS/CTRL words on the processor data bus, selected by the address decoder's enable.
- Raises a level interrupt while codes are pending.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (>= 16)
FIFO_DEPTH, 8, scan-code entries; power of two, 2..64
SYNC_STAGES, 2, synchroniser flops on ps2_clk/ps2_data (>= 2)
TIMEOUT_CYC, 2500, clk cycles without a PS/2 falling edge before a partial frame is aborted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
DataAdr  in  ADDR_W  bus address; bits[3:2] select register
WriteData  in  DATA_W  bus write data
enable  in  1  chip select from address decoder
MemWrite  in  1  1 = write, 0 = read
ReadData  out  DATA_W  read data, combinational
irq  out  1  interrupt request, level
code  out  8  most recently received valid scan code (debug/LEDs)

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE, FIFO empty, sticky flags 0, CTRL = 0x1 (rx_en=1, irq_en=0).
  - code = 0x00, irq = 0.
  - ReadData = 0 unless selected.
- Synchroniser: SYNC_STAGES flops on each PS/2 input. A falling edge is synced ps2_clk 1 -> 0 between consecutive clk cycles.
- Rx FSM (advances only on a falling edge):
  - IDLE: sampled data=0 (start bit) and rx_en=1 -> DATA, bit count 0. Otherwise stay.
  - DATA: shift bit in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: return to IDLE in all cases; the frame is valid if stop=1 and data^parity has odd weight.
    - Valid frame: push the byte and update code in the same clk cycle.
    - Invalid frame: set perr, no push.
- Timeout: in any state other than IDLE, a counter clears on each falling edge. On reaching TIMEOUT_CYC the FSM goes to IDLE, the partial frame is discarded, and perr is set.
- rx_en cleared mid-frame: the current frame completes; new start bits are ignored.
- Register map (word offset = DataAdr[3:2]):
  - 0 DATA, read: {0, fifo_head[7:0]}. Returns 0 when empty.
  - 1 STATUS, read: [0] not_empty, [1] full, [2] ovf, [3] perr, [15:8] count.
  - 1 STATUS, write: 1s in bits[3:2] clear the matching flags (write-1-to-clear).
  - 2 CTRL, read/write: [0] rx_en, [1] irq_en.
  - 3: reads 0, writes ignored.
- ReadData is combinational: value of the selected register when enable=1 and MemWrite=0, else 0.
- Pop: happens at the clk edge ending a cycle with enable=1, MemWrite=0, offset 0, FIFO non-empty. Pop when empty has no effect.
- Push and pop in the same cycle:
  - Both occur; count unchanged.
  - When full, the pop frees the slot and the push succeeds.
- Push while full without a pop: byte dropped, ovf set, FIFO unchanged.
- A flag-set event and a W1C write in the same cycle: set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.
- irq = irq_en & (not_empty | ovf | perr), registered (one clk after the cause).

Decomposition:
- Package ps2_mmio_pkg:
  - register offset constants REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2;
  - STATUS bit-index constants;
  - rx FSM enum {IDLE, DATA, PARITY, STOP}.
- One sub-module: ps2_sync_fifo (parametrised DEPTH/WIDTH, push/pop/full/empty/count), reusable by the other SoC peripherals.

Test Plan:
- Frame 0x1C with parity 0, stop 1, ps2_clk at 12.5 kHz:
  - after the stop-bit falling edge, STATUS reads 0x0101 and code = 0x1C;
  - DATA read returns 0x1C; next STATUS = 0x0000.
- Frame 0x1C sent with parity 1 (wrong): no push, STATUS = 0x0008. Write 0x8 to STATUS -> STATUS = 0x0000.
- Full-FIFO overflow:
  - 9 valid frames 0x01..0x09 with DEPTH=8 -> STATUS = 0x0806 (count 8, full, ovf);
  - 8 DATA reads return 0x01..0x08; a 9th read returns 0.
- Timeout: start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYC+10 cycles -> FSM IDLE, perr=1. A following valid frame 0x2A is received correctly.
- Simultaneous push/pop: FIFO full (count 8) and a DATA read in the same clk as the stop-bit push -> count stays 8, ovf stays 0.
- Interrupt and reset:
  - CTRL=0x3 with one code pending -> irq=1 one clk later;
  - reset asserted mid-frame (after bit 4) -> irq=0, STATUS=0, CTRL=0x1 immediately;
  - after reset release, a new frame 0x5A is received correctly.
